// File: rtl/npu_synchronization_defines.sv
// rtl/npu_synchronization_defines.sv - shared sync-core message types and constants
//
// Purpose: types exchanged between the network interface and the sync-core
//          pipeline stages, plus the width of the optional arbiter
//          performance counters.
// Ports:   none (package).
package npu_synchronization_defines;

  localparam int BARRIER_W       = 8;
  localparam int CNT_BARRIER_W   = 8;
  localparam int TILE_W          = 8;
  localparam int SYNC_ARB_PERF_W = 32;

  typedef logic [BARRIER_W-1:0]     barrier_t;
  typedef logic [CNT_BARRIER_W-1:0] cnt_barrier_t;

  typedef struct packed {
    barrier_t          id_barrier;
    cnt_barrier_t      cnt_setted;
    logic [TILE_W-1:0] id_tile_src;
  } sync_account_message_t;

  // Two accounts conflict when they update the same barrier.
  function automatic logic same_barrier(input sync_account_message_t a,
                                        input sync_account_message_t b);
    return a.id_barrier == b.id_barrier;
  endfunction

endpackage

// File: rtl/sync_account_fifo.sv
// rtl/sync_account_fifo.sv - per-channel account message FIFO
//
// Purpose: small synchronous FIFO holding account messages of one channel.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset (empties the FIFO)
//   push_i, data_i    write request and message (ignored when full)
//   pop_i             read request (ignored when empty)
//   full_o, empty_o   status from the registered pointers only
//   head_o            oldest entry, meaningful when !empty_o
module sync_account_fifo
  import npu_synchronization_defines::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  sync_account_message_t data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output sync_account_message_t head_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  sync_account_message_t mem_q [FIFO_DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/synchronization_account_arbiter.sv
// rtl/synchronization_account_arbiter.sv - multi-channel account issue stage with barrier hazard blocking
//
// Purpose: buffers account messages from NUM_CH network-interface channels,
//          round-robin arbitrates among FIFO heads and issues at most one
//          account per cycle to stage 2, holding back any head whose barrier
//          is already in flight (output register or downstream pending slots).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ni_account_mess[_valid]    per-channel input message / valid
//   ss1_account_consumed       per-channel accept (combinational)
//   ni_release_almost_full     blocks all grants while high
//   ss1_account_mess/valid/ch  registered issued account and its channel
//   haz_pending_mess/valid     downstream accounts still in flight
//   perf_hazard_stall          (SYNC_ARB_PERF_EN) per-channel hazard stall cycles
//   perf_full_stall            (SYNC_ARB_PERF_EN) per-channel rejected-input cycles
// Build option: define SYNC_ARB_PERF_EN to add the saturating stall counters.
module synchronization_account_arbiter
  import npu_synchronization_defines::*;
#(
  parameter int TILE_ID    = 0,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int HAZ_DEPTH  = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  sync_account_message_t [NUM_CH-1:0]    ni_account_mess,
  input  logic [NUM_CH-1:0]                     ni_account_mess_valid,
  output logic [NUM_CH-1:0]                     ss1_account_consumed,
  input  logic                                  ni_release_almost_full,
  output sync_account_message_t                 ss1_account_mess,
  output logic                                  ss1_account_valid,
  output logic [CH_W-1:0]                       ss1_account_ch,
  input  sync_account_message_t [HAZ_DEPTH-1:0] haz_pending_mess,
  input  logic [HAZ_DEPTH-1:0]                  haz_pending_valid
`ifdef SYNC_ARB_PERF_EN
  ,
  output logic [NUM_CH-1:0][SYNC_ARB_PERF_W-1:0] perf_hazard_stall,
  output logic [NUM_CH-1:0][SYNC_ARB_PERF_W-1:0] perf_full_stall
`endif
);

  sync_account_message_t [NUM_CH-1:0] head;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] hazard;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] pop;

  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] grant_ch;
  logic [CH_W:0]   scan_idx;
  logic            grant_any;

  logic                  ss1_valid_q, ss1_valid_d;
  sync_account_message_t ss1_mess_q, ss1_mess_d;
  logic [CH_W-1:0]       ss1_ch_q, ss1_ch_d;

  // Full comes from registered pointers, so a full FIFO popping this cycle
  // still rejects: no same-cycle push-through.
  assign ss1_account_consumed = ni_account_mess_valid & ~fifo_full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_account_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk),
      .rst_ni (reset),
      .push_i (ss1_account_consumed[c]),
      .data_i (ni_account_mess[c]),
      .pop_i  (pop[c]),
      .full_o (fifo_full[c]),
      .empty_o(fifo_empty[c]),
      .head_o (head[c])
    );
  end

  // A head is blocked if its barrier matches the account just issued or any
  // valid downstream pending slot.
  always_comb begin
    hazard   = '0;
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hazard[c] = ss1_valid_q && same_barrier(ss1_mess_q, head[c]);
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        hazard[c] = hazard[c] | (haz_pending_valid[k] && same_barrier(haz_pending_mess[k], head[c]));
      end
      eligible[c] = !fifo_empty[c] && !hazard[c] && !ni_release_almost_full;
    end
  end

  // First eligible channel starting at rr_q, wrapping modulo NUM_CH.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_q} + (CH_W+1)'(i);
      if (scan_idx >= (CH_W+1)'(NUM_CH)) begin
        scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
      end
      if (!grant_any && eligible[scan_idx[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_ch  = scan_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_any) begin
      pop[grant_ch] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_any) begin
      rr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    end
  end

  assign ss1_valid_d = grant_any;
  assign ss1_mess_d  = grant_any ? head[grant_ch] : '0;
  assign ss1_ch_d    = grant_ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= '0;
      ss1_valid_q <= 1'b0;
      ss1_mess_q  <= '0;
      ss1_ch_q    <= '0;
    end else begin
      rr_q        <= rr_d;
      ss1_valid_q <= ss1_valid_d;
      ss1_mess_q  <= ss1_mess_d;
      ss1_ch_q    <= ss1_ch_d;
    end
  end

  assign ss1_account_valid = ss1_valid_q;
  assign ss1_account_mess  = ss1_mess_q;
  assign ss1_account_ch    = ss1_ch_q;

`ifdef SYNC_ARB_PERF_EN
  logic [NUM_CH-1:0][SYNC_ARB_PERF_W-1:0] hazard_stall_cnt_q;
  logic [NUM_CH-1:0][SYNC_ARB_PERF_W-1:0] full_stall_cnt_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hazard_stall_cnt_q <= '0;
      full_stall_cnt_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!fifo_empty[c] && hazard[c] && (hazard_stall_cnt_q[c] != '1)) begin
          hazard_stall_cnt_q[c] <= hazard_stall_cnt_q[c] + 1'b1;
        end
        if (ni_account_mess_valid[c] && fifo_full[c] && (full_stall_cnt_q[c] != '1)) begin
          full_stall_cnt_q[c] <= full_stall_cnt_q[c] + 1'b1;
        end
      end
    end
  end

  assign perf_hazard_stall = hazard_stall_cnt_q;
  assign perf_full_stall   = full_stall_cnt_q;
`endif

endmodule
